// File: rtl/writeback_scoreboard_pkg.sv
// Shared types for the writeback path: register-file geometry and the
// result record carried by execute and memory stages.
package writeback_scoreboard_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } result_t;

endpackage

// File: rtl/writeback_scoreboard_if.sv
// Issue, ALU, load and register-file write signals of the writeback block.
// master drives decode/execute/memory side, slave is the scoreboard.
interface writeback_scoreboard_if;
    import writeback_scoreboard_pkg::*;

    logic                  issue_valid;
    logic                  issue_has_rd;
    logic [REG_ADDR_W-1:0] issue_rd;
    logic [REG_ADDR_W-1:0] issue_rs1;
    logic [REG_ADDR_W-1:0] issue_rs2;
    logic                  stall;

    logic                  alu_valid;
    logic                  alu_ready;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_data;

    logic                  load_valid;
    logic [REG_ADDR_W-1:0] load_rd;
    logic [XLEN-1:0]       load_data;

    logic                  write_enable;
    logic [REG_ADDR_W-1:0] addr_rd;
    logic [XLEN-1:0]       data_rd;

    modport master (
        output issue_valid, issue_has_rd, issue_rd, issue_rs1, issue_rs2,
        output alu_valid, alu_rd, alu_data,
        output load_valid, load_rd, load_data,
        input  stall, alu_ready,
        input  write_enable, addr_rd, data_rd
    );

    modport slave (
        input  issue_valid, issue_has_rd, issue_rd, issue_rs1, issue_rs2,
        input  alu_valid, alu_rd, alu_data,
        input  load_valid, load_rd, load_data,
        output stall, alu_ready,
        output write_enable, addr_rd, data_rd
    );

endinterface

// File: rtl/writeback_scoreboard_result_fifo.sv
// Small synchronous skid FIFO holding ALU results that lost write-port
// arbitration; reset clears the pointers, storage is left as is.
module result_fifo
    import writeback_scoreboard_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  result_t                  push_data,
    input  logic                     pop,
    output result_t                  pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    result_t              mem [DEPTH];
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [PTR_W:0]       count_q;
    logic                 do_push;
    logic                 do_pop;

    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem[head];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[tail] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                tail <= tail + 1'b1;
            end
            if (do_pop) begin
                head <= head + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/writeback_scoreboard.sv
// Register-file write port owner: merges load and ALU results onto one
// registered write port and tracks in-flight destinations for decode.
module writeback_scoreboard
    import writeback_scoreboard_pkg::result_t;
    import writeback_scoreboard_pkg::REG_ADDR_W;
    import writeback_scoreboard_pkg::NUM_REGS;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int XLEN       = 32
) (
    input logic                  clock,
    input logic                  reset,
    writeback_scoreboard_if.slave bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_REGS-1:0]   pending;
    logic [NUM_REGS-1:0]   pending_next;
    logic                  issue_fire;

    result_t               fifo_head;
    result_t               alu_result;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_push;
    logic                  fifo_pop;

    logic                  alu_accept;
    logic                  bypass;
    logic                  win_valid;
    result_t               win;

    logic                  we_q;
    logic [REG_ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]       data_q;

    assign bus.stall = bus.issue_valid
        && (pending[bus.issue_rs1]
            || pending[bus.issue_rs2]
            || (bus.issue_has_rd && pending[bus.issue_rd]));

    assign issue_fire = bus.issue_valid && !bus.stall;

    always_comb begin
        pending_next = pending;
        if (we_q) begin
            pending_next[addr_q] = 1'b0;
        end
        // set after clear so a same-edge reissue keeps the bit
        if (issue_fire && bus.issue_has_rd && (bus.issue_rd != '0)) begin
            pending_next[bus.issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    // ready comes from registered occupancy only, never from a same-cycle pop
    assign bus.alu_ready = !fifo_full;
    assign alu_accept    = bus.alu_valid && bus.alu_ready;
    assign alu_result    = '{rd: bus.alu_rd, data: bus.alu_data};
    assign bypass        = !bus.load_valid && (fifo_count == '0)
                           && bus.alu_valid;

    always_comb begin
        win_valid = 1'b0;
        win       = '0;
        fifo_pop  = 1'b0;
        if (bus.load_valid) begin
            win_valid = 1'b1;
            win       = '{rd: bus.load_rd, data: bus.load_data};
        end else if (!fifo_empty) begin
            win_valid = 1'b1;
            win       = fifo_head;
            fifo_pop  = 1'b1;
        end else if (bypass) begin
            win_valid = 1'b1;
            win       = alu_result;
        end
    end

    assign fifo_push = alu_accept && !bypass;

    result_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_result_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (alu_result),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // x0 winners are consumed silently; address/data keep their last value
    always_ff @(posedge clock) begin
        if (reset) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q <= win_valid && (win.rd != '0);
            if (win_valid && (win.rd != '0)) begin
                addr_q <= win.rd;
                data_q <= win.data;
            end
        end
    end

    assign bus.write_enable = we_q;
    assign bus.addr_rd      = addr_q;
    assign bus.data_rd      = data_q;

endmodule

// File: tb/tb_writeback_scoreboard.sv
// Directed checks of arbitration, skid buffering, scoreboard and reset.
module tb_writeback_scoreboard;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int checks = 0;
    int fails  = 0;

    writeback_scoreboard_if bus ();

    writeback_scoreboard #(
        .FIFO_DEPTH (4),
        .XLEN       (32)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.issue_valid  = 1'b0;
        bus.issue_has_rd = 1'b0;
        bus.issue_rd     = '0;
        bus.issue_rs1    = '0;
        bus.issue_rs2    = '0;
        bus.alu_valid    = 1'b0;
        bus.alu_rd       = '0;
        bus.alu_data     = '0;
        bus.load_valid   = 1'b0;
        bus.load_rd      = '0;
        bus.load_data    = '0;
    endtask

    task automatic check_write(input string tag, input logic [4:0] rd,
                               input logic [31:0] data);
        check({tag, "_we"}, 64'(bus.write_enable), 64'd1);
        check({tag, "_addr"}, 64'(bus.addr_rd), 64'(rd));
        check({tag, "_data"}, 64'(bus.data_rd), 64'(data));
    endtask

    initial begin
        int rds [3];
        rds = '{2, 9, 12};

        idle();
        step();
        step();
        check("rst_we", 64'(bus.write_enable), 64'd0);
        check("rst_addr", 64'(bus.addr_rd), 64'd0);
        check("rst_data", 64'(bus.data_rd), 64'd0);
        check("rst_ready", 64'(bus.alu_ready), 64'd1);
        check("rst_stall", 64'(bus.stall), 64'd0);
        reset = 1'b0;
        #1;
        check("post_rst_we", 64'(bus.write_enable), 64'd0);
        check("post_rst_ready", 64'(bus.alu_ready), 64'd1);
        bus.issue_valid = 1'b1;
        bus.issue_rs1   = 5'd5;
        #1;
        check("issue_rs5_stall", 64'(bus.stall), 64'd0);
        step();
        check("idle_we", 64'(bus.write_enable), 64'd0);

        // RAW on x7 cleared by a bypassed ALU write
        bus.issue_valid  = 1'b1;
        bus.issue_has_rd = 1'b1;
        bus.issue_rd     = 5'd7;
        bus.issue_rs1    = 5'd0;
        #1;
        check("issue_rd7_stall", 64'(bus.stall), 64'd0);
        step();
        bus.issue_has_rd = 1'b0;
        bus.issue_rd     = 5'd0;
        bus.issue_rs1    = 5'd7;
        bus.alu_valid    = 1'b1;
        bus.alu_rd       = 5'd7;
        bus.alu_data     = 32'hDEADBEEF;
        #1;
        check("raw7_stall", 64'(bus.stall), 64'd1);
        check("raw7_ready", 64'(bus.alu_ready), 64'd1);
        step();
        bus.alu_valid = 1'b0;
        check_write("alu7", 5'd7, 32'hDEADBEEF);
        check("raw7_stall_hold", 64'(bus.stall), 64'd1);
        step();
        check("alu7_we_drop", 64'(bus.write_enable), 64'd0);
        check("raw7_stall_clear", 64'(bus.stall), 64'd0);
        idle();

        // load beats ALU; ALU result follows from the FIFO
        bus.load_valid = 1'b1;
        bus.load_rd    = 5'd3;
        bus.load_data  = 32'h11;
        bus.alu_valid  = 1'b1;
        bus.alu_rd     = 5'd4;
        bus.alu_data   = 32'h22;
        step();
        idle();
        check_write("ld3", 5'd3, 32'h11);
        step();
        check_write("fifo4", 5'd4, 32'h22);
        step();
        check("race_idle_we", 64'(bus.write_enable), 64'd0);

        // six loads back to back while the ALU keeps offering results
        for (int i = 0; i < 6; i++) begin
            bus.load_valid = 1'b1;
            bus.load_rd    = 5'd1;
            bus.load_data  = 32'h100 + 32'(i);
            bus.alu_valid  = 1'b1;
            bus.alu_rd     = 5'(20 + (i < 4 ? i : 4));
            bus.alu_data   = 32'hA0 + 32'(i < 4 ? i : 4);
            #1;
            check($sformatf("fill%0d_ready", i), 64'(bus.alu_ready),
                  64'(i < 4));
            step();
            check_write($sformatf("fill%0d", i), 5'd1, 32'h100 + 32'(i));
        end
        bus.load_valid = 1'b0;
        bus.alu_rd     = 5'd24;
        bus.alu_data   = 32'hA4;
        #1;
        check("drain_full_ready", 64'(bus.alu_ready), 64'd0);
        step();
        check_write("drain0", 5'd20, 32'hA0);
        check("drain_ready_back", 64'(bus.alu_ready), 64'd1);
        step();
        bus.alu_valid = 1'b0;
        check_write("drain1", 5'd21, 32'hA1);
        step();
        check_write("drain2", 5'd22, 32'hA2);
        step();
        check_write("drain3", 5'd23, 32'hA3);
        step();
        check_write("drain4", 5'd24, 32'hA4);
        step();
        check("drain_done_we", 64'(bus.write_enable), 64'd0);
        check("drain_done_ready", 64'(bus.alu_ready), 64'd1);

        // x0 destinations
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd0;
        bus.alu_data  = 32'h55;
        step();
        bus.alu_valid = 1'b0;
        check("x0_alu_we", 64'(bus.write_enable), 64'd0);
        bus.issue_valid  = 1'b1;
        bus.issue_has_rd = 1'b1;
        bus.issue_rd     = 5'd0;
        #1;
        check("x0_issue_stall", 64'(bus.stall), 64'd0);
        step();
        #1;
        check("x0_reissue_stall", 64'(bus.stall), 64'd0);
        idle();
        step();

        // partially fill FIFO, mark 2/9/12 pending, then reset
        for (int k = 0; k < 3; k++) begin
            bus.load_valid   = 1'b1;
            bus.load_rd      = 5'd15;
            bus.load_data    = 32'h300 + 32'(k);
            bus.alu_valid    = 1'b1;
            bus.alu_rd       = 5'(25 + k);
            bus.alu_data     = 32'h400 + 32'(k);
            bus.issue_valid  = 1'b1;
            bus.issue_has_rd = 1'b1;
            bus.issue_rd     = 5'(rds[k]);
            #1;
            check($sformatf("prerst%0d_stall", k), 64'(bus.stall), 64'd0);
            step();
        end
        idle();
        bus.issue_valid = 1'b1;
        bus.issue_rs1   = 5'd9;
        #1;
        check("prerst_raw9_stall", 64'(bus.stall), 64'd1);
        reset = 1'b1;
        step();
        check("midrst_we", 64'(bus.write_enable), 64'd0);
        check("midrst_stall9", 64'(bus.stall), 64'd0);
        check("midrst_ready", 64'(bus.alu_ready), 64'd1);
        reset = 1'b0;
        bus.issue_rs1 = 5'd12;
        bus.issue_rs2 = 5'd2;
        #1;
        check("postrst_stall", 64'(bus.stall), 64'd0);
        check("postrst_data", 64'(bus.data_rd), 64'd0);
        idle();
        step();
        check("postrst_fifo_empty_we", 64'(bus.write_enable), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
